// File: rtl/frequency_readout_if.sv
// Result channel of the frequency readout: averaged period plus timeout qualifier
// on a valid/ready handshake toward the row/column readout mux.
interface frequency_readout_if #(
    parameter int COUNT_WIDTH = 16
);
    logic [COUNT_WIDTH-1:0] data;
    logic                   valid;
    logic                   ready;
    logic                   timeout_flag;

    modport master (
        output data,
        output valid,
        output timeout_flag,
        input  ready
    );

    modport slave (
        input  data,
        input  valid,
        input  timeout_flag,
        output ready
    );
endinterface

// File: rtl/frequency_readout.sv
// Measures the period of an asynchronous square wave in clk cycles, averaged over
// 2**AVG_LOG2 periods, with stall timeout and a single-entry output register.
module frequency_readout #(
    parameter int COUNT_WIDTH    = 16,
    parameter int AVG_LOG2       = 2,
    parameter int TIMEOUT_CYCLES = 65000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                clear_i,
    input  logic                freq_i,
    frequency_readout_if.master out_if,
    output logic                overrun_o,
    output logic                busy_o
);

    localparam int ACC_W = COUNT_WIDTH + AVG_LOG2;
    localparam int N_W   = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

    localparam logic [COUNT_WIDTH-1:0] TIMEOUT_VAL = COUNT_WIDTH'(TIMEOUT_CYCLES);
    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX   = '1;
    localparam logic [N_W-1:0]         N_LAST      = N_W'((1 << AVG_LOG2) - 1);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_MEASURE = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Input synchroniser and rising-edge detect
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   delay_q;
    logic                   rise;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q[0] <= 1'b0;
        end else begin
            sync_q[0] <= freq_i;
        end
    end

    for (genvar gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
        always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
                sync_q[gi] <= 1'b0;
            end else begin
                sync_q[gi] <= sync_q[gi-1];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            delay_q <= 1'b0;
        end else begin
            delay_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~delay_q;

    // ------------------------------------------------------------------
    // Measurement FSM
    // ------------------------------------------------------------------
    state_t                 state_q;
    logic                   busy_q;
    logic [COUNT_WIDTH-1:0] counter_q;
    logic [ACC_W-1:0]       acc_q;
    logic [N_W-1:0]         n_q;
    logic                   res_valid_q;
    logic [COUNT_WIDTH-1:0] res_data_q;
    logic                   res_timeout_q;

    logic [ACC_W-1:0]       sum_d;
    logic [COUNT_WIDTH-1:0] avg_d;
    logic                   last_period;

    // Accumulator is wide enough to hold 2**AVG_LOG2 saturated periods.
    assign sum_d       = acc_q + ACC_W'(counter_q);
    assign avg_d       = sum_d[ACC_W-1:AVG_LOG2];
    assign last_period = (n_q == N_LAST);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q       <= ST_IDLE;
            busy_q        <= 1'b0;
            counter_q     <= '0;
            acc_q         <= '0;
            n_q           <= '0;
            res_valid_q   <= 1'b0;
            res_data_q    <= '0;
            res_timeout_q <= 1'b0;
        end else if (clear_i) begin
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            counter_q   <= '0;
            acc_q       <= '0;
            n_q         <= '0;
            res_valid_q <= 1'b0;
        end else begin
            res_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    counter_q <= '0;
                    acc_q     <= '0;
                    n_q       <= '0;
                    if (rise) begin
                        state_q   <= ST_MEASURE;
                        busy_q    <= 1'b1;
                        counter_q <= COUNT_WIDTH'(1);
                    end
                end
                ST_MEASURE: begin
                    if (rise) begin
                        // The edge that closes this period also opens the next one.
                        counter_q <= COUNT_WIDTH'(1);
                        if (last_period) begin
                            res_valid_q   <= 1'b1;
                            res_data_q    <= avg_d;
                            res_timeout_q <= 1'b0;
                            acc_q         <= '0;
                            n_q           <= '0;
                        end else begin
                            acc_q <= sum_d;
                            n_q   <= n_q + N_W'(1);
                        end
                    end else if (counter_q == TIMEOUT_VAL) begin
                        res_valid_q   <= 1'b1;
                        res_data_q    <= '1;
                        res_timeout_q <= 1'b1;
                        state_q       <= ST_IDLE;
                        busy_q        <= 1'b0;
                        counter_q     <= '0;
                        acc_q         <= '0;
                        n_q           <= '0;
                    end else if (counter_q != COUNT_MAX) begin
                        counter_q <= counter_q + COUNT_WIDTH'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o = busy_q;

    // ------------------------------------------------------------------
    // Single-entry output register with overrun detection
    // ------------------------------------------------------------------
    logic                   valid_q;
    logic [COUNT_WIDTH-1:0] data_q;
    logic                   timeout_q;
    logic                   overrun_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            valid_q   <= 1'b0;
            data_q    <= '0;
            timeout_q <= 1'b0;
            overrun_q <= 1'b0;
        end else if (clear_i) begin
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            overrun_q <= 1'b0;
        end else if (res_valid_q) begin
            // A held result is never overwritten; the newcomer is dropped instead.
            if (!valid_q || out_if.ready) begin
                valid_q   <= 1'b1;
                data_q    <= res_data_q;
                timeout_q <= res_timeout_q;
            end else begin
                overrun_q <= 1'b1;
            end
        end else if (valid_q && out_if.ready) begin
            valid_q <= 1'b0;
        end
    end

    assign out_if.valid        = valid_q;
    assign out_if.data         = data_q;
    assign out_if.timeout_flag = timeout_q;
    assign overrun_o           = overrun_q;

endmodule
